// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the fetch stage and its PC register.
// Reset PC, NOP encoding and the sequential PC step live here.
package fetch_stage_pkg;

  localparam logic [31:0] PC_RESET      = 32'h0000_3000;
  localparam logic [31:0] INSTR_NOP     = 32'h0000_0000;
  localparam logic [31:0] PC_STEP       = 32'd4;
  localparam logic [31:0] LINK_OFFSET   = 32'd8;
  localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    NpcSeq,
    NpcRedirect,
    NpcHold
  } npc_sel_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc8;
    logic        valid;
  } d_stage_t;

  // Branch targets are word addresses; the two low bits are discarded.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Fetch PC register with next-PC selection (sequential, redirect or hold).
// The PC output is taken straight from the flop.
module pc_reg
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] target_i,
  output logic [31:0] pc_o
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  npc_sel_e    npc_sel;

  // A stall masks the redirect; the hazard unit presents it again later.
  always_comb begin
    npc_sel = NpcSeq;
    if (stall_i) begin
      npc_sel = NpcHold;
    end else if (redirect_i) begin
      npc_sel = NpcRedirect;
    end
  end

  always_comb begin
    pc_d = pc_q;
    unique case (npc_sel)
      NpcSeq:      pc_d = pc_q + PC_STEP;
      NpcRedirect: pc_d = align_word(target_i);
      NpcHold:     pc_d = pc_q;
      default:     pc_d = pc_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= PC_RESET;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC register, F->D pipeline registers and a saturating stall counter.
// Define FETCH_SQUASH_DELAY_SLOT_EN to turn the delay-slot instruction into a bubble on redirect.
module fetch_stage
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        npc_redirect,
  input  logic [31:0] npc_target,
  input  logic [31:0] imem_rdata,
  output logic [31:0] F_PC,
  output logic [31:0] D_Instr,
  output logic [31:0] D_PC,
  output logic [31:0] D_PC8,
  output logic        D_Valid,
  output logic [15:0] stall_cnt
);

  logic [31:0] f_pc;
  d_stage_t    d_q;
  d_stage_t    d_d;
  logic [15:0] stall_cnt_q;
  logic [15:0] stall_cnt_d;

  pc_reg u_pc_reg (
    .clk        (clk),
    .reset      (reset),
    .stall_i    (stall),
    .redirect_i (npc_redirect),
    .target_i   (npc_target),
    .pc_o       (f_pc)
  );

  always_comb begin
    d_d = d_q;
    if (!stall) begin
      d_d.instr = imem_rdata;
      d_d.pc    = f_pc;
      d_d.pc8   = f_pc + LINK_OFFSET;
      d_d.valid = 1'b1;
`ifdef FETCH_SQUASH_DELAY_SLOT_EN
      // The slot keeps its PC so the link address stays meaningful.
      if (npc_redirect) begin
        d_d.instr = INSTR_NOP;
        d_d.valid = 1'b0;
      end
`endif
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != STALL_CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      d_q.instr   <= INSTR_NOP;
      d_q.pc      <= 32'h0;
      d_q.pc8     <= 32'h0;
      d_q.valid   <= 1'b0;
      stall_cnt_q <= 16'h0;
    end else begin
      d_q         <= d_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign F_PC      = f_pc;
  assign D_Instr   = d_q.instr;
  assign D_PC      = d_q.pc;
  assign D_PC8     = d_q.pc8;
  assign D_Valid   = d_q.valid;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, stall-counter saturation and
// randomized traffic against a behavioural model of the fetch rules.
module tb_fetch_stage;

`ifdef FETCH_SQUASH_DELAY_SLOT_EN
  localparam bit SQ = 1'b1;
`else
  localparam bit SQ = 1'b0;
`endif

  localparam logic [31:0] IM = 32'h2408_0001;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        npc_redirect;
  logic [31:0] npc_target;
  logic [31:0] imem_rdata;
  logic [31:0] F_PC;
  logic [31:0] D_Instr;
  logic [31:0] D_PC;
  logic [31:0] D_PC8;
  logic        D_Valid;
  logic [15:0] stall_cnt;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .npc_redirect (npc_redirect),
    .npc_target   (npc_target),
    .imem_rdata   (imem_rdata),
    .F_PC         (F_PC),
    .D_Instr      (D_Instr),
    .D_PC         (D_PC),
    .D_PC8        (D_PC8),
    .D_Valid      (D_Valid),
    .stall_cnt    (stall_cnt)
  );

  typedef struct {
    logic        rst;
    logic        stl;
    logic        rdr;
    logic [31:0] tgt;
    logic [31:0] imem;
    logic [31:0] fpc;
    logic [31:0] dpc;
    logic [31:0] dpc8;
    logic [31:0] dinstr;
    logic        dvalid;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[16];

  int n_chk  = 0;
  int n_fail = 0;

  // Behavioural model: what the D stage and PC hold after each edge.
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_dpc;
  logic [31:0] m_dpc8;
  logic        m_valid;
  int unsigned m_cnt;

  function automatic vec_t mk(logic rst, logic stl, logic rdr, logic [31:0] tgt,
                              logic [31:0] imem, logic [31:0] fpc, logic [31:0] dpc,
                              logic [31:0] dpc8, logic [31:0] dinstr, logic dvalid,
                              logic [15:0] cnt);
    vec_t v;
    v.rst = rst; v.stl = stl; v.rdr = rdr; v.tgt = tgt; v.imem = imem;
    v.fpc = fpc; v.dpc = dpc; v.dpc8 = dpc8; v.dinstr = dinstr;
    v.dvalid = dvalid; v.cnt = cnt;
    return v;
  endfunction

  function automatic void model_edge();
    if (reset) begin
      m_pc = 32'h3000; m_instr = 0; m_dpc = 0; m_dpc8 = 0; m_valid = 0; m_cnt = 0;
    end else if (stall) begin
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
    end else begin
      m_dpc   = m_pc;
      m_dpc8  = m_pc + 32'd8;
      m_instr = (SQ && npc_redirect) ? 32'h0 : imem_rdata;
      m_valid = !(SQ && npc_redirect);
      m_pc    = npc_redirect ? {npc_target[31:2], 2'b00} : m_pc + 32'd4;
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_state(input string tag, input logic [31:0] fpc, input logic [31:0] dpc,
                           input logic [31:0] dpc8, input logic [31:0] dinstr,
                           input logic dvalid, input logic [15:0] cnt);
    chk({tag, ".F_PC"}, F_PC, fpc);
    chk({tag, ".D_PC"}, D_PC, dpc);
    chk({tag, ".D_PC8"}, D_PC8, dpc8);
    chk({tag, ".D_Instr"}, D_Instr, dinstr);
    chk({tag, ".D_Valid"}, {31'h0, D_Valid}, {31'h0, dvalid});
    chk({tag, ".stall_cnt"}, {16'h0, stall_cnt}, {16'h0, cnt});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_edge();
  endtask

  initial begin
    logic [31:0] rd_i;
    logic [31:0] rd_v;
    logic [31:0] held_pc;

    rd_i = SQ ? 32'h0 : 32'hAAAA_0001;
    rd_v = SQ ? 32'h0 : 32'h1;
    //            rst stl rdr tgt           imem          fpc           dpc           dpc8          instr          v  cnt
    vecs[0]  = mk(1, 0, 0, 32'h0,         IM,           32'h3000,     32'h0,        32'h0,        32'h0,         0, 0);
    vecs[1]  = mk(0, 0, 0, 32'h0,         IM,           32'h3004,     32'h3000,     32'h3008,     IM,            1, 0);
    vecs[2]  = mk(0, 0, 0, 32'h0,         IM,           32'h3008,     32'h3004,     32'h300C,     IM,            1, 0);
    vecs[3]  = mk(0, 1, 0, 32'h0,         IM,           32'h3008,     32'h3004,     32'h300C,     IM,            1, 1);
    vecs[4]  = mk(0, 1, 0, 32'h0,         IM,           32'h3008,     32'h3004,     32'h300C,     IM,            1, 2);
    vecs[5]  = mk(0, 0, 0, 32'h0,         IM,           32'h300C,     32'h3008,     32'h3010,     IM,            1, 2);
    vecs[6]  = mk(0, 0, 0, 32'h0,         IM,           32'h3010,     32'h300C,     32'h3014,     IM,            1, 2);
    vecs[7]  = mk(0, 0, 1, 32'h3043,      32'hAAAA0001, 32'h3040,     32'h3010,     32'h3018,     rd_i,          rd_v[0], 2);
    vecs[8]  = mk(0, 1, 1, 32'h4000,      IM,           32'h3040,     32'h3010,     32'h3018,     rd_i,          rd_v[0], 3);
    vecs[9]  = mk(0, 0, 1, 32'h4000,      32'h11112222, 32'h4000,     32'h3040,     32'h3048,     SQ ? 32'h0 : 32'h11112222, rd_v[0], 3);
    vecs[10] = mk(0, 0, 1, 32'hFFFFFFFC,  32'h33334444, 32'hFFFFFFFC, 32'h4000,     32'h4008,     SQ ? 32'h0 : 32'h33334444, rd_v[0], 3);
    vecs[11] = mk(0, 0, 0, 32'h0,         IM,           32'h0,        32'hFFFFFFFC, 32'h4,        IM,            1, 3);
    vecs[12] = mk(0, 1, 0, 32'h0,         IM,           32'h0,        32'hFFFFFFFC, 32'h4,        IM,            1, 4);
    vecs[13] = mk(0, 1, 0, 32'h0,         IM,           32'h0,        32'hFFFFFFFC, 32'h4,        IM,            1, 5);
    vecs[14] = mk(1, 1, 1, 32'h5000,      IM,           32'h3000,     32'h0,        32'h0,        32'h0,         0, 0);
    vecs[15] = mk(0, 0, 0, 32'h0,         IM,           32'h3004,     32'h3000,     32'h3008,     IM,            1, 0);

    reset = 1'b1; stall = 1'b0; npc_redirect = 1'b0; npc_target = 32'h0; imem_rdata = IM;
    m_pc = 0; m_instr = 0; m_dpc = 0; m_dpc8 = 0; m_valid = 0; m_cnt = 0;

    for (int i = 0; i < 16; i++) begin
      reset        = vecs[i].rst;
      stall        = vecs[i].stl;
      npc_redirect = vecs[i].rdr;
      npc_target   = vecs[i].tgt;
      imem_rdata   = vecs[i].imem;
      tick();
      chk_state($sformatf("vec%0d", i), vecs[i].fpc, vecs[i].dpc, vecs[i].dpc8,
                vecs[i].dinstr, vecs[i].dvalid, vecs[i].cnt);
    end

    // F_PC must not react combinationally to stall/redirect between edges.
    held_pc = F_PC;
    stall = 1'b1; npc_redirect = 1'b1; npc_target = 32'h0000_5000;
    #2;
    chk("comb_path.F_PC", F_PC, held_pc);
    stall = 1'b0;
    #1;
    chk("comb_path2.F_PC", F_PC, held_pc);
    npc_redirect = 1'b0;

    // Long stall: counter must stop at 0xFFFF while PC holds at 0x3004.
    stall = 1'b1;
    for (int i = 0; i < 65540; i++) tick();
    chk("sat.stall_cnt", {16'h0, stall_cnt}, 32'h0000_FFFF);
    chk("sat.F_PC", F_PC, 32'h3004);
    stall = 1'b0;
    tick();
    chk("sat_resume.F_PC", F_PC, 32'h3008);
    chk("sat_resume.stall_cnt", {16'h0, stall_cnt}, 32'h0000_FFFF);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      reset        = ($urandom_range(39) == 0);
      stall        = ($urandom_range(3) == 0);
      npc_redirect = ($urandom_range(4) == 0);
      npc_target   = $urandom;
      imem_rdata   = $urandom;
      tick();
      chk_state($sformatf("rnd%0d", i), m_pc, m_dpc, m_dpc8, m_instr, m_valid,
                m_cnt[15:0]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset: `clk` and `reset`; all state updates on posedge `clk`.
REQ-002 `clk`  input  1  system clock.
REQ-003 `reset`  input  1  synchronous active-high reset; overrides every other input.
REQ-004 `stall`  input  1  from hazard unit; hold PC and D-stage registers.
REQ-005 `npc_redirect`  input  1  taken branch/jump resolved in D stage.
REQ-006 `npc_target`  input  32  redirect target PC.
REQ-007 `imem_rdata`  input  32  instruction word at `F_PC`, combinational read.
REQ-008 `F_PC`  output  32  current fetch PC, drives the instruction-memory address.
REQ-009 `D_Instr`  output  32  instruction latched into D stage.
REQ-010 `D_PC`  output  32  PC of `D_Instr`.
REQ-011 `D_PC8`  output  32  `D_PC` + 8, link address.
REQ-012 `D_Valid`  output  1  D-stage slot holds a fetched instruction, not a bubble.
REQ-013 `stall_cnt`  output  16  saturating count of stalled cycles since reset.

Function
REQ-014 PC register SHALL advance PC+4 per cycle when neither `stall` nor `npc_redirect` is set; mod-2^32 wrap: 0xFFFF_FFFC -> 0x0000_0000.
REQ-015 `npc_redirect`=1 and `stall`=0: PC SHALL load {`npc_target`[31:2], 2'b00}; low two target bits are ignored.
REQ-016 `stall`=1: PC, `D_Instr`, `D_PC`, `D_PC8`, `D_Valid` SHALL hold; `npc_redirect` is ignored that cycle (hazard unit re-presents it).
REQ-017 `stall`=0: D registers SHALL load `imem_rdata`, `F_PC`, `F_PC`+8, 1 in the same edge that PC updates (1-cycle latency fetch->D).
REQ-018 Default (no macro): on redirect, the instruction at the current `F_PC` (delay slot) SHALL still be latched into D, `D_Valid`=1.
REQ-019 `D_PC8` SHALL always equal `D_PC`+8 mod 2^32, including wrap.
REQ-020 `stall_cnt` SHALL increment by 1 each cycle `stall`=1 and saturate at 0xFFFF.
REQ-021 `F_PC` SHALL be a pure register output (no combinational path from `stall`/`npc_*`).

Reset
REQ-022 On `reset`: PC=0x0000_3000, `D_Instr`=0 (nop), `D_PC`=0, `D_PC8`=0, `D_Valid`=0, `stall_cnt`=0.
REQ-023 `reset` asserted together with `stall` or `npc_redirect` SHALL produce the reset state only.
REQ-024 First edge after reset release with `stall`=0 SHALL load D from PC 0x0000_3000.

Configuration
REQ-025 Macro `FETCH_SQUASH_DELAY_SLOT_EN`: when defined, a redirect edge (`npc_redirect`=1, `stall`=0) SHALL load D with `D_Instr`=0, `D_Valid`=0, `D_PC`=`F_PC`, `D_PC8`=`F_PC`+8; when undefined, REQ-018 applies.

Structure
REQ-026 Shared package SHALL hold `PC_RESET` (32'h0000_3000), `INSTR_NOP` (32'h0), and `PC_STEP` (4).
REQ-027 One sub-module `pc_reg` SHALL hold the PC register and next-PC select; D-stage registers and counter SHALL live in `fetch_stage`.

Verification
REQ-028 Reset, then 3 free-run cycles with imem returning 0x2408_0001 -> `F_PC` 0x3000, 0x3004, 0x3008, 0x300C; `D_PC` 0x3000 on cycle 1, `D_PC8` 0x3008.
REQ-029 At `F_PC`=0x3008, 2-cycle `stall` -> `F_PC` and D hold 2 cycles, `stall_cnt`=2, then resume at 0x300C.
REQ-030 At `F_PC`=0x3010, `npc_redirect`=1, target 0x3043 -> next `F_PC`=0x3040; `D_PC`=0x3010, `D_Valid`=1 (macro off) or `D_Instr`=0, `D_Valid`=0 (macro on).
REQ-031 `stall`=1 and `npc_redirect`=1 same cycle, target 0x4000 -> PC unchanged; redirect next cycle with `stall`=0 -> `F_PC`=0x4000.
REQ-032 Redirect to 0xFFFF_FFFC, one free cycle -> `F_PC`=0x0000_0000, `D_PC8`=0x0000_0004.
REQ-033 `reset` pulsed mid-stall with `stall_cnt`=5 -> next cycle `F_PC`=0x3000, `stall_cnt`=0, `D_Valid`=0.
